// File: rtl/pattern_tx.sv
// Nibble-stream transmitter feeding a 4-bit pattern detector: sends fixed
// 4-nibble frames or a user word, optionally repeated, with idle gaps.
module pattern_tx #(
    parameter int unsigned GAP         = 0,
    parameter logic [3:0]  IDLE_NIBBLE = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [15:0] payload,
    input  logic [3:0]  rep,
    input  logic        abort,
    output logic [3:0]  dout,
    output logic        dout_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic        HAS_GAP  = (GAP != 0);
    localparam logic [3:0]  GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;
    localparam logic [15:0] PATTERN1 = 16'h0531;
    localparam logic [15:0] PATTERN2 = 16'h0619;

    state_t      state;
    state_t      next_state;

    logic [1:0]  sel_q;
    logic [15:0] payload_q;
    logic [3:0]  rep_q;

    logic [1:0]  idx;
    logic [3:0]  frame_cnt;
    logic [3:0]  gap_cnt;
    logic        err_q;

    logic        accept;
    logic        illegal;
    logic        last_nibble;

    // Nibble i of the selected frame; index 0 is the most significant nibble.
    function automatic logic [3:0] nibble_at(input logic [1:0]  s,
                                             input logic [15:0] word,
                                             input logic [1:0]  i);
        logic [15:0] frame;
        logic [3:0]  nib;
        case (s)
            2'b00:   frame = PATTERN1;
            2'b01:   frame = PATTERN2;
            default: frame = word;
        endcase
        case (i)
            2'd0:    nib = frame[15:12];
            2'd1:    nib = frame[11:8];
            2'd2:    nib = frame[7:4];
            default: nib = frame[3:0];
        endcase
        return nib;
    endfunction

    assign accept      = (state == S_IDLE) && start && (sel != 2'b11);
    assign illegal     = (state == S_IDLE) && start && (sel == 2'b11);
    assign last_nibble = (idx == 2'd3) && (frame_cnt == rep_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = S_SEND;
            end
            S_SEND: begin
                if (abort)            next_state = S_IDLE;
                else if (last_nibble) next_state = S_DONE;
                else if (HAS_GAP)     next_state = S_GAP;
                else                  next_state = S_SEND;
            end
            S_GAP: begin
                if (abort)               next_state = S_IDLE;
                else if (gap_cnt == 4'd0) next_state = S_SEND;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        dout       = IDLE_NIBBLE;
        dout_valid = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        err        = err_q;
        case (state)
            S_SEND: begin
                dout_valid = 1'b1;
                dout       = nibble_at(sel_q, payload_q, idx);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencing counters: nibble index, frame count, gap down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= 2'd0;
            frame_cnt <= 4'd0;
            gap_cnt   <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= illegal;
            if (accept) begin
                idx       <= 2'd0;
                frame_cnt <= 4'd0;
            end else if ((state == S_SEND) && !abort && !last_nibble) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) frame_cnt <= frame_cnt + 4'd1;
            end
            if ((state == S_SEND) && (next_state == S_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    // Request copies are only captured on an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel_q     <= sel;
            payload_q <= payload;
            rep_q     <= rep;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: one instance with no gap, one with a 2-cycle gap,
// plus a reference nibble-window detector on each output stream.
module tb_pattern_tx;

    logic        clk;
    logic        reset_n;
    logic        start0, start2;
    logic [1:0]  sel;
    logic [15:0] payload;
    logic [3:0]  rep;
    logic        abort;

    logic [3:0]  dout0, dout2;
    logic        dv0, dv2, busy0, busy2, done0, done2, err0, err2;

    int total = 0;
    int bad   = 0;

    pattern_tx #(.GAP(0), .IDLE_NIBBLE(4'hF)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .sel(sel), .payload(payload),
        .rep(rep), .abort(abort), .dout(dout0), .dout_valid(dv0), .busy(busy0),
        .done(done0), .err(err0)
    );

    pattern_tx #(.GAP(2), .IDLE_NIBBLE(4'hF)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .sel(sel), .payload(payload),
        .rep(rep), .abort(abort), .dout(dout2), .dout_valid(dv2), .busy(busy2),
        .done(done2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream monitor, sampled on the falling edge.
    logic [3:0]  vq0[$];
    logic [3:0]  vq2[$];
    logic [4:0]  seq2[$];
    logic [15:0] hist0 = 16'hFFFF;
    logic [15:0] hist2 = 16'hFFFF;
    int done0c = 0, done2c = 0, err0c = 0, err2c = 0, busy0c = 0;
    int p1c0 = 0, p2c0 = 0, p1c2 = 0, p2c2 = 0;

    always @(negedge clk) begin
        if (dv0) begin
            vq0.push_back(dout0);
            if ({hist0[11:0], dout0} == 16'h0531) p1c0++;
            if ({hist0[11:0], dout0} == 16'h0619) p2c0++;
            hist0 = {hist0[11:0], dout0};
        end
        if (dv2) begin
            vq2.push_back(dout2);
            if ({hist2[11:0], dout2} == 16'h0531) p1c2++;
            if ({hist2[11:0], dout2} == 16'h0619) p2c2++;
            hist2 = {hist2[11:0], dout2};
        end
        if (busy2) seq2.push_back({dv2, dout2});
        if (done0) done0c++;
        if (done2) done2c++;
        if (err0)  err0c++;
        if (err2)  err2c++;
        if (busy0) busy0c++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pack0(input int b);
        if (vq0.size() < b + 4) return 16'hxxxx;
        return {vq0[b], vq0[b+1], vq0[b+2], vq0[b+3]};
    endfunction

    function automatic logic [15:0] pack2(input int b);
        if (vq2.size() < b + 4) return 16'hxxxx;
        return {vq2[b], vq2[b+1], vq2[b+2], vq2[b+3]};
    endfunction

    int b_nv, b_done, b_busy, b_p1, b_p2, b_err, b_seq, mism;
    logic [4:0]  exp_seq[$];
    logic [15:0] p2_frame;

    initial begin
        reset_n = 1'b1; start0 = 1'b0; start2 = 1'b0;
        sel = 2'b00; payload = 16'h0000; rep = 4'd0; abort = 1'b0;

        // Power-up reset, asserted between edges.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_dout",  32'(dout0), 32'hF);
        chk("rst_valid", 32'(dv0),   32'h0);
        chk("rst_busy",  32'(busy0), 32'h0);
        chk("rst_done",  32'(done0), 32'h0);
        chk("rst_err",   32'(err0),  32'h0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        // Pattern1, single frame, no gap.
        b_nv = vq0.size(); b_done = done0c; b_busy = busy0c; b_p1 = p1c0;
        sel = 2'b00; rep = 4'd0; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        chk("a_first_valid", 32'(dv0),   32'h1);
        chk("a_first_nib",   32'(dout0), 32'h0);
        cyc(8);
        chk("a_count", 32'(vq0.size() - b_nv), 32'd4);
        chk("a_nibs",  32'(pack0(b_nv)),       32'h0531);
        chk("a_done",  32'(done0c - b_done),   32'd1);
        chk("a_busy",  32'(busy0c - b_busy),   32'd5);
        chk("a_det",   32'(p1c0 - b_p1),       32'd1);

        // Pattern2 x3 with 2-cycle gaps; a start and input changes mid-transfer are ignored.
        b_nv = vq2.size(); b_done = done2c; b_p2 = p2c2; b_seq = seq2.size(); b_err = err2c;
        sel = 2'b01; rep = 4'd2; start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        cyc(9);
        sel = 2'b00; rep = 4'd0; payload = 16'hBEEF; start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        cyc(32);
        exp_seq.delete();
        p2_frame = 16'h0619;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 4; n++) begin
                exp_seq.push_back({1'b1, p2_frame[15 - 4*n -: 4]});
                if (!(f == 2 && n == 3)) begin
                    exp_seq.push_back(5'h0F);
                    exp_seq.push_back(5'h0F);
                end
            end
        end
        exp_seq.push_back(5'h0F);
        chk("b_seq_len", 32'(seq2.size() - b_seq), 32'(exp_seq.size()));
        mism = 0;
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (b_seq + i >= seq2.size() || seq2[b_seq + i] !== exp_seq[i]) mism++;
        end
        chk("b_seq_mismatches", 32'(mism), 32'd0);
        chk("b_count", 32'(vq2.size() - b_nv), 32'd12);
        chk("b_done",  32'(done2c - b_done),   32'd1);
        chk("b_det",   32'(p2c2 - b_p2),       32'd3);
        chk("b_no_err", 32'(err2c - b_err),    32'd0);

        // Payload words.
        b_nv = vq0.size(); b_p1 = p1c0; b_done = done0c;
        sel = 2'b10; rep = 4'd0; payload = 16'h0531; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(6);
        chk("c_nibs", 32'(pack0(b_nv)),  32'h0531);
        chk("c_det",  32'(p1c0 - b_p1),  32'd1);
        b_nv = vq0.size(); b_p1 = p1c0;
        payload = 16'h0A31; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(6);
        chk("c2_nibs", 32'(pack0(b_nv)),   32'h0A31);
        chk("c2_det",  32'(p1c0 - b_p1),   32'd0);
        chk("c_done",  32'(done0c - b_done), 32'd2);

        // Illegal select.
        b_nv = vq0.size(); b_err = err0c; b_busy = busy0c;
        sel = 2'b11; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        chk("e_err_hi",  32'(err0),  32'h1);
        chk("e_busy",    32'(busy0), 32'h0);
        chk("e_valid",   32'(dv0),   32'h0);
        cyc(1);
        chk("e_err_lo",  32'(err0),  32'h0);
        cyc(4);
        chk("e_err_cnt", 32'(err0c - b_err),      32'd1);
        chk("e_no_nibs", 32'(vq0.size() - b_nv),  32'd0);
        chk("e_no_busy", 32'(busy0c - b_busy),    32'd0);

        // Abort on the third nibble, then a clean restart.
        b_nv = vq0.size(); b_done = done0c;
        sel = 2'b00; rep = 4'd0; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(2);
        chk("f_third_nib", 32'(dout0), 32'h3);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("f_valid_low", 32'(dv0),   32'h0);
        chk("f_busy_low",  32'(busy0), 32'h0);
        cyc(5);
        chk("f_count", 32'(vq0.size() - b_nv), 32'd3);
        chk("f_no_done", 32'(done0c - b_done), 32'd0);
        b_nv = vq0.size();
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(8);
        chk("f_restart_nibs", 32'(pack0(b_nv)),    32'h0531);
        chk("f_restart_done", 32'(done0c - b_done), 32'd1);

        // Sixteen frames: rep=15 must not wrap.
        b_nv = vq0.size(); b_done = done0c; b_busy = busy0c; b_p1 = p1c0;
        sel = 2'b00; rep = 4'd15; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(70);
        chk("g_count", 32'(vq0.size() - b_nv), 32'd64);
        chk("g_det",   32'(p1c0 - b_p1),       32'd16);
        chk("g_done",  32'(done0c - b_done),   32'd1);
        chk("g_busy",  32'(busy0c - b_busy),   32'd65);
        chk("g_last",  32'(pack0(b_nv + 60)),  32'h0531);

        // Asynchronous reset in the middle of a gap.
        sel = 2'b00; rep = 4'd0; start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        cyc(1);
        chk("h_in_gap", 32'({busy2, dv2}), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("h_rst_busy",  32'(busy2), 32'h0);
        chk("h_rst_valid", 32'(dv2),   32'h0);
        chk("h_rst_dout",  32'(dout2), 32'hF);
        chk("h_rst_done",  32'(done2), 32'h0);
        b_nv = vq2.size(); b_done = done2c;
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        chk("h_no_residual", 32'(vq2.size() - b_nv), 32'd0);
        chk("h_no_done",     32'(done2c - b_done),   32'd0);
        start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        chk("h_first_valid", 32'({dv2, dout2}), 32'h10);
        cyc(12);
        chk("h_nibs", 32'(pack2(b_nv)),      32'h0531);
        chk("h_done", 32'(done2c - b_done),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Nibble-stream transmitter: the sending end of the 4-bit pattern detector interface.
- On a start request, emits one of two fixed 4-nibble frames, or a user 16-bit word, as a strobed nibble stream.
- `dout`/`dout_valid` connect directly to the detector's `din`/`enable`.
- Used as an on-chip stimulus source and link-test generator.

Parameters:
- GAP, 0, idle cycles (`dout_valid` low) inserted between consecutive nibbles and between frames; legal range 0..15.
- IDLE_NIBBLE, 4'hF, value driven on `dout` whenever `dout_valid` is low; must be nonzero.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- sel  input  2  frame select: 00 = pattern1 (0,5,3,1); 01 = pattern2 (0,6,1,9); 10 = payload word; 11 = illegal
- payload  input  16  word for sel=10, sent nibble [15:12] first, [3:0] last
- rep  input  4  frames to send minus one (0 → 1 frame, 15 → 16 frames)
- abort  input  1  synchronous cancel
- dout  output  4  nibble to detector `din`
- dout_valid  output  1  nibble strobe to detector `enable`
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at normal completion
- err  output  1  one-cycle pulse on an illegal start

Behaviour:
- Reset (`reset_n` low, asynchronous, any state): state=IDLE, `dout`=IDLE_NIBBLE, `dout_valid`=0, `busy`=0, `done`=0, `err`=0; all counters cleared. Outputs change immediately, without waiting for a clock edge. A frame in flight is dropped with no `done`.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - `start`=1 and sel≠11: latch sel, payload, rep; clear nibble index (2b) and frame count (4b); next state SEND.
  - `start`=1 and sel=11: `err`=1 on the next cycle for one cycle; stay IDLE.
- SEND: `dout_valid`=1 for exactly one cycle; `dout`=nibble[index] of the latched frame.
  - Not last nibble of the last frame: advance the index (wrap 3→0 and increment the frame count at the end of a frame). Next state is GAP if GAP>0, else SEND.
  - Last nibble of the last frame: next state DONE. No trailing gap is inserted.
- GAP: `dout_valid`=0, `dout`=IDLE_NIBBLE; 4-bit down-counter loaded with GAP on entry; returns to SEND after exactly GAP cycles.
- DONE: `done`=1 for one cycle, `busy` still 1; next state IDLE.
- `busy`=1 in SEND, GAP and DONE; 0 in IDLE.
- Latency: first `dout_valid` appears in the cycle after `start` is sampled. A single frame occupies 4+3·GAP valid/idle cycles, followed by one DONE cycle.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE. Minimum spacing between frame-set starts is therefore 4+3·GAP+2 cycles for one frame.
- `start` while busy: ignored, with no queuing and no `err`.
- sel/payload/rep changes while busy: ignored; the latched copies are used.
- `abort`:
  - In SEND/GAP/DONE: next state IDLE; `dout_valid` drops next cycle; no `done`. A `done` already being driven in the DONE cycle still completes.
  - In IDLE: no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- Frame count compare is 4-bit: rep=15 yields exactly 16 frames (64 valid nibbles), with no wrap to 0.

Test Plan:
- Reset then start, sel=00, rep=0, GAP=0 → `dout` 0,5,3,1 on four consecutive valid cycles; `done` on the next cycle; a connected detector pulses pattern1 once; `busy` spans 5 cycles.
- sel=01, rep=2, GAP=2 → 12 valid nibbles 0,6,1,9 ×3, each separated by exactly 2 cycles of `dout_valid`=0 with `dout`=4'hF; detector pattern2 pulses 3 times; `done` exactly once.
- sel=10, payload=16'h0531 → nibbles 0,5,3,1 and detector pattern1. Then payload=16'h0A31 → nibbles 0,A,3,1 with no detector hit.
- sel=11 start → `err` high 1 cycle, `busy` stays 0, `dout_valid` never asserts. Start pulsed during a busy transfer → ignored, and the nibble count is unchanged.
- abort asserted on the 3rd valid nibble of sel=00 → `dout_valid` low from the next cycle, `busy` 0, no `done`; a fresh start then sends the full frame.
- reset_n driven low mid-GAP (asynchronous, between clock edges) → outputs reach reset values before the next edge. After release, no residual nibbles are sent and the first start behaves as from power-up.
